// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Counts a loaded number of seconds down to zero and flags expiry. The game
// controller loads the typing time for a round, runs or pauses it with
// enable, and ends the round on done/expired. timeLeft drives the display.
//
// Parameters:
//   CLK_PER_SEC  clk cycles per second (>= 2)
//   TIME_W       width of loaded / remaining time in seconds
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   load      in   one-cycle request to start a countdown from loadTime
//   loadTime  in   duration in seconds, sampled only when load=1
//   enable    in   level, 1 = run, 0 = pause
//   timeLeft  out  remaining whole seconds (registered)
//   running   out  high while counting (RUN)
//   tick      out  one-cycle pulse on each one-second decrement
//   done      out  one-cycle pulse on entry to EXPIRED
//   expired   out  level, high while EXPIRED
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int CLK_PER_SEC = 100000000,
    parameter int TIME_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] loadTime,
    input  logic              enable,
    output logic [TIME_W-1:0] timeLeft,
    output logic              running,
    output logic              tick,
    output logic              done,
    output logic              expired
);

    localparam int            PS_W   = $clog2(CLK_PER_SEC);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PS_W-1:0]    ps, ps_nxt;
    logic [TIME_W-1:0]  tl_nxt;
    logic               tick_nxt;
    logic               done_nxt;

    // Decrement that floors at zero so timeLeft can never wrap.
    function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        state_nxt = state;
        ps_nxt    = ps;
        tl_nxt    = timeLeft;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;

        if (load) begin
            // A load wins over any tick due this cycle and restarts the second.
            ps_nxt = '0;
            if (loadTime == '0) begin
                tl_nxt    = '0;
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
            end else begin
                tl_nxt    = loadTime;
                state_nxt = enable ? RUN : PAUSE;
            end
        end else begin
            case (state)
                IDLE: begin
                    tl_nxt = '0;
                end
                RUN: begin
                    if (!enable) begin
                        // Prescaler holds so the partial second survives the pause.
                        state_nxt = PAUSE;
                    end else if (ps == PS_MAX) begin
                        ps_nxt   = '0;
                        tl_nxt   = sat_dec(timeLeft);
                        tick_nxt = 1'b1;
                        if (timeLeft <= TIME_W'(1)) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        ps_nxt = ps + 1'b1;
                    end
                end
                PAUSE: begin
                    if (enable) state_nxt = RUN;
                end
                EXPIRED: begin
                    tl_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ps       <= '0;
            timeLeft <= '0;
            running  <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ps       <= ps_nxt;
            timeLeft <= tl_nxt;
            running  <= (state_nxt == RUN);
            tick     <= tick_nxt;
            done     <= done_nxt;
            expired  <= (state_nxt == EXPIRED);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int CPS = 4;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [TW-1:0] loadTime;
    logic          enable;
    logic [TW-1:0] timeLeft;
    logic          running;
    logic          tick;
    logic          done;
    logic          expired;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(.CLK_PER_SEC(CPS), .TIME_W(TW)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .loadTime (loadTime),
        .enable   (enable),
        .timeLeft (timeLeft),
        .running  (running),
        .tick     (tick),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then settle before sampling / driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all0(input string tag);
        check({tag, ".timeLeft"}, timeLeft, 0);
        check({tag, ".running"},  running,  0);
        check({tag, ".tick"},     tick,     0);
        check({tag, ".done"},     done,     0);
        check({tag, ".expired"},  expired,  0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; loadTime = '0; enable = 1'b0;
        cyc(); cyc();
        check_all0("reset");

        // Test 1: load 3, run to expiry
        reset = 1'b0; load = 1'b1; loadTime = 4'd3; enable = 1'b1;
        cyc();
        load = 1'b0;
        check("t1.load.timeLeft", timeLeft, 3);
        check("t1.load.running",  running,  1);
        check("t1.load.tick",     tick,     0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("t1.tick@%0d", k),     tick,     (k % 4 == 0) ? 1 : 0);
            check($sformatf("t1.tl@%0d", k),       timeLeft, 3 - k / 4);
            check($sformatf("t1.done@%0d", k),     done,     (k == 12) ? 1 : 0);
            check($sformatf("t1.expired@%0d", k),  expired,  (k == 12) ? 1 : 0);
            check($sformatf("t1.running@%0d", k),  running,  (k == 12) ? 0 : 1);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t1.hold.done",    done,     0);
            check("t1.hold.expired", expired,  1);
            check("t1.hold.tl",      timeLeft, 0);
            check("t1.hold.tick",    tick,     0);
            check("t1.hold.running", running,  0);
        end

        // Test 2: pause keeps partial second
        load = 1'b1; loadTime = 4'd5; enable = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        check("t2.pre.tl", timeLeft, 5);
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("t2.pause.running", running,  0);
            check("t2.pause.tl",      timeLeft, 5);
            check("t2.pause.tick",    tick,     0);
        end
        enable = 1'b1;
        cyc();
        check("t2.resume.running", running, 1);
        check("t2.resume.tick",    tick,    0);
        cyc();
        check("t2.r1.tick", tick, 0);
        cyc();
        check("t2.r2.tick", tick,     1);
        check("t2.r2.tl",   timeLeft, 4);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t2.next.tick", tick, (k == 3) ? 1 : 0);
        end
        check("t2.next.tl", timeLeft, 3);

        // Test 4: load in the cycle a tick is due
        load = 1'b1; loadTime = 4'd3; enable = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("t4.first.tick", tick,     1);
        check("t4.first.tl",   timeLeft, 2);
        cyc(); cyc(); cyc();
        load = 1'b1; loadTime = 4'd9;
        cyc();
        load = 1'b0;
        check("t4.reload.tl",      timeLeft, 9);
        check("t4.reload.tick",    tick,     0);
        check("t4.reload.running", running,  1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t4.next.tick", tick, (k == 3) ? 1 : 0);
        end
        check("t4.next.tl", timeLeft, 8);

        // Test 3: load zero expires immediately
        load = 1'b1; loadTime = 4'd0;
        cyc();
        load = 1'b0;
        check("t3.expired", expired,  1);
        check("t3.done",    done,     1);
        check("t3.tl",      timeLeft, 0);
        check("t3.tick",    tick,     0);
        check("t3.running", running,  0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t3.after.done",    done,    0);
            check("t3.after.tick",    tick,    0);
            check("t3.after.expired", expired, 1);
        end

        // Test 5: reset in RUN and in EXPIRED, simultaneous load ignored
        load = 1'b1; loadTime = 4'd7; enable = 1'b1;
        cyc();
        load = 1'b0;
        check("t5.run.tl", timeLeft, 7);
        reset = 1'b1; load = 1'b1; loadTime = 4'd9;
        cyc();
        check_all0("t5.rst_run");
        reset = 1'b0; load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_all0("t5.idle");
        end
        load = 1'b1; loadTime = 4'd0;
        cyc();
        load = 1'b0;
        check("t5.exp", expired, 1);
        reset = 1'b1; load = 1'b1; loadTime = 4'd6;
        cyc();
        check_all0("t5.rst_exp");
        reset = 1'b0; load = 1'b0;

        // Test 6: load 1 paused, then run to expiry
        load = 1'b1; loadTime = 4'd1; enable = 1'b0;
        cyc();
        load = 1'b0;
        check("t6.load.running", running,  0);
        check("t6.load.tl",      timeLeft, 1);
        check("t6.load.expired", expired,  0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t6.hold.tl",   timeLeft, 1);
            check("t6.hold.tick", tick,     0);
        end
        enable = 1'b1;
        cyc();
        check("t6.resume.running", running, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t6.tick",    tick,     (k == 3) ? 1 : 0);
            check("t6.done",    done,     (k == 3) ? 1 : 0);
            check("t6.tl",      timeLeft, (k == 3) ? 0 : 1);
            check("t6.expired", expired,  (k == 3) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
